unidade_controle_quiz: RTL

- Parametrised successor of the quiz-game control unit.
- Sequences a game of N_RODADAS questions:
  - loads each question;
  - waits for a player answer under a per-question timeout;
  - classifies each question as hit, miss or timeout;
  - ends on the last round (victory) or on reaching MAX_ERROS misses/timeouts (defeat).
- Sits between the datapath (question memory, answer register, comparator) and the display/top level.
- Owns the round, hit, error and timer counters internally; these counters were previously in the datapath.

---
 rtl/unidade_controle_quiz_pkg.sv | 32 +++
 rtl/unidade_controle_quiz_if.sv | 39 +++
 rtl/unidade_controle_quiz_contador_timer.sv | 28 ++
 rtl/unidade_controle_quiz.sv | 111 +++++++++++
 4 files changed

// File: rtl/unidade_controle_quiz_pkg.sv
// Shared definitions for the quiz-game control unit: state encoding and
// the width helpers used to size the round/hit/error counters and the timer.
package quiz_pkg;

  // State codes are visible on db_estado; gaps 11..13 are unused codes.
  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARA     = 4'd1,
    CARREGA     = 4'd2,
    MOSTRA      = 4'd3,
    ESPERA      = 4'd4,
    REGISTRA    = 4'd5,
    COMPARA     = 4'd6,
    ACERTO      = 4'd7,
    ERRO        = 4'd8,
    TIMEOUT     = 4'd9,
    AVALIA      = 4'd10,
    FIM_VITORIA = 4'd14,
    FIM_DERROTA = 4'd15
  } estado_t;

  // Width able to hold 0..n (hit/error counts can reach n).
  function automatic int largura_rodada(input int n);
    return $clog2(n + 1);
  endfunction

  // Width able to hold 0..t, never narrower than one bit.
  function automatic int largura_timer(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/unidade_controle_quiz_if.sv
// Bundle between the quiz control unit and the datapath/display side.
//
// Handshake: there is no back-pressure. jogada_feita is a one-cycle pulse
// that is consumed only while the controller sits in ESPERA and ignored in
// every other state; resposta_correta must be stable from the REGISTRA cycle
// through the COMPARA cycle. iniciar is a level, sampled only in INICIAL and
// in the two FIM states. All controller outputs are registered-state decodes.
interface unidade_controle_quiz_if #(
  parameter int WR = 5,
  parameter int WT = 13
);
  logic          iniciar;
  logic          jogada_feita;
  logic          resposta_correta;
  logic          zeraR;
  logic          zeraM;
  logic          registraM;
  logic          registraR;
  logic [WR-1:0] rodada;
  logic [WR-1:0] acertos;
  logic [WR-1:0] erros;
  logic [WT-1:0] tempo_restante;
  logic          timeout_evento;
  logic          pronto;
  logic          venceu;
  logic [3:0]    db_estado;

  modport master (
    input  iniciar, jogada_feita, resposta_correta,
    output zeraR, zeraM, registraM, registraR, rodada, acertos, erros,
           tempo_restante, timeout_evento, pronto, venceu, db_estado
  );

  modport slave (
    output iniciar, jogada_feita, resposta_correta,
    input  zeraR, zeraM, registraM, registraR, rodada, acertos, erros,
           tempo_restante, timeout_evento, pronto, venceu, db_estado
  );
endinterface

// File: rtl/unidade_controle_quiz_contador_timer.sv
// Down-counter for the per-question answer timer. Loads VALOR_CARGA, counts
// down while enabled, sticks at zero, and flags expiry when it reads 1.
module contador_timer #(
  parameter int W           = 13,
  parameter int VALOR_CARGA = 5000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         carrega,
  input  logic         habilita,
  output logic [W-1:0] valor,
  output logic         expira
);
  localparam logic [W-1:0] CARGA = W'(VALOR_CARGA);

  // Load has priority over counting; holds whenever neither is requested.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valor <= '0;
    end else if (carrega) begin
      valor <= CARGA;
    end else if (habilita && (valor != '0)) begin
      valor <= valor - W'(1);
    end
  end

  assign expira = (valor == W'(1));
endmodule

// File: rtl/unidade_controle_quiz.sv
// Quiz-game control unit: sequences N_RODADAS questions, times each answer,
// scores hits/misses/timeouts and ends in victory or defeat. Owns the round,
// hit and error counters plus the answer timer.
module unidade_controle_quiz
  import quiz_pkg::*;
#(
  parameter int N_RODADAS      = 16,
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int MAX_ERROS      = 3
) (
  input logic                     clock,
  input logic                     reset,
  unidade_controle_quiz_if.master bus
);
  localparam int WR = largura_rodada(N_RODADAS);
  localparam int WT = largura_timer(TIMEOUT_CICLOS);
  localparam logic [WR-1:0] CONT_MAX = '1;

  estado_t       estado, proximo;
  logic [WR-1:0] rodada, acertos, erros;
  logic [WT-1:0] tempo;
  logic          timer_carrega, timer_habilita, timer_expira;
  logic          derrota, ultima;

  // AVALIA runs one cycle after the score update, so these see fresh counts.
  assign derrota = (MAX_ERROS != 0) && (32'(erros) == MAX_ERROS);
  assign ultima  = (32'(rodada) == N_RODADAS - 1);

  contador_timer #(
    .W           (WT),
    .VALOR_CARGA (TIMEOUT_CICLOS)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .carrega  (timer_carrega),
    .habilita (timer_habilita),
    .valor    (tempo),
    .expira   (timer_expira)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= proximo;
  end

  // Next-state and timer control; an answer beats an expiring timer.
  always_comb begin
    proximo        = estado;
    timer_carrega  = 1'b0;
    timer_habilita = 1'b0;
    case (estado)
      INICIAL:  if (bus.iniciar) proximo = PREPARA;
      PREPARA:  proximo = CARREGA;
      CARREGA:  proximo = MOSTRA;
      MOSTRA: begin
        timer_carrega = 1'b1;
        proximo       = ESPERA;
      end
      ESPERA: begin
        if (bus.jogada_feita)                        proximo = REGISTRA;
        else if ((TIMEOUT_CICLOS != 0) && timer_expira) proximo = TIMEOUT;
        else                                         timer_habilita = 1'b1;
      end
      REGISTRA: proximo = COMPARA;
      COMPARA:  proximo = bus.resposta_correta ? ACERTO : ERRO;
      ACERTO, ERRO, TIMEOUT: proximo = AVALIA;
      AVALIA: begin
        if (derrota)     proximo = FIM_DERROTA;
        else if (ultima) proximo = FIM_VITORIA;
        else             proximo = CARREGA;
      end
      FIM_VITORIA, FIM_DERROTA: if (bus.iniciar) proximo = INICIAL;
      default:  proximo = INICIAL;
    endcase
  end

  // Round/hit/error counters: cleared in INICIAL, saturating, held in FIM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rodada  <= '0;
      acertos <= '0;
      erros   <= '0;
    end else begin
      case (estado)
        INICIAL: begin
          rodada  <= '0;
          acertos <= '0;
          erros   <= '0;
        end
        ACERTO:  if (acertos != CONT_MAX) acertos <= acertos + WR'(1);
        ERRO, TIMEOUT: if (erros != CONT_MAX) erros <= erros + WR'(1);
        AVALIA:  if (!derrota && !ultima) rodada <= rodada + WR'(1);
        default: ;
      endcase
    end
  end

  assign bus.zeraR          = (estado == INICIAL);
  assign bus.zeraM          = (estado == INICIAL);
  assign bus.registraM      = (estado == CARREGA);
  assign bus.registraR      = (estado == REGISTRA);
  assign bus.timeout_evento = (estado == TIMEOUT);
  assign bus.pronto         = (estado == FIM_VITORIA) || (estado == FIM_DERROTA);
  assign bus.venceu         = (estado == FIM_VITORIA);
  assign bus.db_estado      = estado;
  assign bus.rodada         = rodada;
  assign bus.acertos        = acertos;
  assign bus.erros          = erros;
  assign bus.tempo_restante = tempo;
endmodule
